bus_slave_mult: RTL and testbench



---
 rtl/sdsu_bus_pkg.sv | 19 +
 rtl/mult_seq_core.sv | 63 ++++++
 rtl/bus_slave_mult.sv | 88 ++++++++
 tb/tb_bus_slave_mult.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sdsu_bus_pkg.sv
// Shared constants and types for the bus-slave multiplier: register map,
// command bit position and the slave FSM state encoding.
package sdsu_bus_pkg;

  localparam int DATA_W_DFLT = 32;

  localparam logic [31:0] ADDR_CMD  = 32'd0;
  localparam logic [31:0] ADDR_OP_A = 32'd1;
  localparam logic [31:0] ADDR_OP_B = 32'd2;

  localparam int CMD_START_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } slave_state_t;

endpackage

// File: rtl/mult_seq_core.sv
// Fixed-latency sequential shift-add multiplier with its iteration counter.
// Build option MULT_RADIX4_EN retires two multiplier bits per step instead of one.
module mult_seq_core
  import sdsu_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int STEPS  = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(STEPS + 1);

  logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt, pp;
  logic [CNT_W-1:0]  cnt;

`ifdef MULT_RADIX4_EN
  localparam int SH = 2;
  always_comb begin
    unique case (mplier[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = mcand;
      2'd2:    pp = mcand << 1;
      default: pp = (mcand << 1) + mcand;
    endcase
  end
`else
  localparam int SH = 1;
  assign pp = mplier[0] ? mcand : '0;
`endif

  assign acc_nxt = acc + pp;
  // done flags the final step so the caller can capture acc_nxt on the same edge
  assign done    = run && (cnt == CNT_W'(STEPS - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << SH;
      mplier <= mplier >> SH;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_slave_mult.sv
// Bus slave: decodes master writes into OP_A/OP_B/CMD and sequences one multiply
// per start command. Latency halves when built with MULT_RADIX4_EN.
module bus_slave_mult
  import sdsu_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ITERS  = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              exec,
  input  logic              write,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic [DATA_W-1:0] result_data
);

`ifdef MULT_RADIX4_EN
  localparam int STEPS = ITERS / 2;
`else
  localparam int STEPS = ITERS;
`endif

  slave_state_t      state, nxt;
  logic [DATA_W-1:0] op_a, op_b, product;
  logic              wr, start_cmd, load, core_done;

  assign wr        = valid & exec & write;
  assign start_cmd = wr && (address == ADDR_CMD) && data[CMD_START_BIT] && start;

  mult_seq_core #(
    .DATA_W (DATA_W),
    .STEPS  (STEPS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .run     (state == BUSY),
    .a       (op_a),
    .b       (op_b),
    .done    (core_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // A start while BUSY is dropped; DONE accepts one for back-to-back runs
  always_comb begin
    nxt  = state;
    load = 1'b0;
    unique case (state)
      IDLE: if (start_cmd) begin
        load = 1'b1;
        nxt  = BUSY;
      end
      BUSY: if (core_done) nxt = DONE;
      DONE: begin
        nxt = IDLE;
        if (start_cmd) begin
          load = 1'b1;
          nxt  = BUSY;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= 1'b0;
      result_data <= '0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      ready <= (state == BUSY) && core_done;
      if ((state == BUSY) && core_done) result_data <= product;
      if (wr && (address == ADDR_OP_A)) op_a <= data;
      if (wr && (address == ADDR_OP_B)) op_b <= data;
    end
  end

endmodule

// File: tb/tb_bus_slave_mult.sv
// Randomized + directed bench for bus_slave_mult against a transaction-level model
// (product = a*b mod 2^32, ready exactly LAT edges after an accepted start).
module tb_bus_slave_mult;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, exec, write, start;
  logic [31:0] address, data;
  logic        ready;
  logic [31:0] result_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_a, m_b, m_res, m_prod;
  bit          pend;
  int          dl, cyc;

  bus_slave_mult dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .exec        (exec),
    .write       (write),
    .address     (address),
    .data        (data),
    .start       (start),
    .ready       (ready),
    .result_data (result_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check
  task automatic tick();
    logic wr, st_cmd, accept, fin;
    wr     = valid & exec & write;
    st_cmd = wr && (address == 32'd0) && data[0] && start;
    @(posedge clk);
    cyc++;
    fin = 1'b0;
    if (rst) begin
      m_a = '0; m_b = '0; m_res = '0; pend = 1'b0;
    end else begin
      accept = st_cmd && (!pend || cyc > dl);
      if (pend && cyc == dl) begin
        m_res = m_prod;
        fin   = 1'b1;
        pend  = 1'b0;
      end
      if (accept) begin
        pend   = 1'b1;
        dl     = cyc + LAT;
        m_prod = m_a * m_b;
      end
      if (wr && address == 32'd1) m_a = data;
      if (wr && address == 32'd2) m_b = data;
    end
    #1;
    chk("ready", {31'd0, ready}, {31'd0, fin});
    chk("result_data", result_data, m_res);
  endtask

  task automatic drive(input logic v, e, w, input logic [31:0] ad, dt, input logic st);
    valid = v; exec = e; write = w; address = ad; data = dt; start = st;
    tick();
    valid = 1'b0; exec = 1'b0; write = 1'b0; start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] ad, dt, input logic st);
    drive(1'b1, 1'b1, 1'b1, ad, dt, st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; exec = 1'b0; write = 1'b0; start = 1'b0;
    address = '0; data = '0;
    m_a = '0; m_b = '0; m_res = '0; m_prod = '0; pend = 1'b0; dl = 0; cyc = 0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // basic 3*5
    beat(1, 3, 0); beat(2, 5, 0); beat(0, 1, 1);
    idle(LAT + 3);
    // wraparound and truncation
    beat(1, 32'hFFFF_FFFF, 0); beat(2, 2, 0); beat(0, 1, 1); idle(LAT + 2);
    beat(1, 32'h0001_0000, 0); beat(2, 32'h0001_0000, 0); beat(0, 1, 1); idle(LAT + 2);

    // mid-BUSY operand write and ignored restart, then a start that uses OP_A=7
    beat(1, 9, 0); beat(2, 11, 0); beat(0, 1, 1);
    idle(5); beat(1, 7, 0); beat(0, 1, 1);
    idle(LAT); beat(0, 1, 1); idle(LAT + 2);

    // beats that must do nothing
    drive(1, 0, 1, 1, 32'hDEAD, 0);
    drive(1, 1, 0, 2, 32'hBEEF, 0);
    drive(1, 1, 1, 5, 32'h1234, 1);
    drive(0, 1, 1, 0, 1, 1);
    beat(0, 1, 0);
    beat(0, 2, 1);
    idle(LAT + 2);
    beat(0, 1, 1); idle(LAT + 2);

    // reset 10 cycles into BUSY, then a clean run
    beat(1, 123, 0); beat(2, 456, 0); beat(0, 1, 1);
    idle(10); rst = 1'b1; beat(0, 1, 1); rst = 1'b0;
    idle(LAT + 2);
    beat(1, 12, 0); beat(2, 13, 0); beat(0, 1, 1); idle(LAT + 2);

    // back-to-back: second start in the DONE cycle
    beat(1, 3, 0); beat(2, 5, 0); beat(0, 1, 1);
    beat(1, 6, 0); beat(2, 7, 0);
    idle(LAT - 2);
    beat(0, 1, 1);
    idle(LAT + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst     = ($urandom % 400) == 0;
      valid   = ($urandom % 4) != 0;
      exec    = ($urandom % 5) != 0;
      write   = ($urandom % 5) != 0;
      r       = $urandom % 8;
      address = (r < 6) ? 32'($urandom_range(0, 2)) : (r == 6 ? 32'($urandom_range(3, 9)) : $urandom);
      data    = ($urandom % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      start   = ($urandom % 3) != 0;
      tick();
    end
    rst = 1'b0; valid = 1'b0;
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
